math_pow2_pipe: RTL and testbench

//  Parametrised, pipelined base-2 antilog: dout = 2^din, unsigned fixed point in and out.
//  Per-stage valid/ready handshake, tag passthrough and output saturation with overflow flag.

---
 rtl/math_pow2_pipe.sv | 171 +++++++++++++++++
 tb/tb_math_pow2_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/math_pow2_pipe.sv
// math_pow2_pipe: pipelined base-2 antilog, dout = 2^din, unsigned fixed point in and out.
//
// Ports:
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid / in_ready  input handshake; in_ready = !out_valid | out_ready
//   din, in_tag          exponent (INT_W.FRAC_W) and sideband tag
//   out_valid/out_ready  output handshake
//   dout, out_ovf        result (OUT_INT_W.OUT_FRAC_W), saturation flag
//   out_tag              tag travelling with the sample
//
// Three register stages (S1 LUT/exponent, S2 shift, S3 scale/saturate), latency 3,
// throughput 1/cycle. The whole pipeline holds when the output is stalled.
//
// Build option: define MATH_POW2_ROUND_EN for round-half-up in S3 instead of truncation.
// Requires M_W < 59 (ROM is generated with 60 fraction bits of working precision).

module math_pow2_pipe #(
    parameter int unsigned INT_W      = 6,
    parameter int unsigned FRAC_W     = 6,
    parameter int unsigned M_W        = 23,
    parameter int unsigned OUT_INT_W  = 16,
    parameter int unsigned OUT_FRAC_W = 8,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INT_W+FRAC_W-1:0]           din,
    input  logic [TAG_W-1:0]                  in_tag,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_INT_W+OUT_FRAC_W-1:0]   dout,
    output logic                              out_ovf,
    output logic [TAG_W-1:0]                  out_tag
);

    localparam int unsigned D_W = OUT_INT_W + OUT_FRAC_W;
    localparam int unsigned P_W = M_W + OUT_INT_W + 1;
    localparam int unsigned S_W = P_W + 1;
    localparam int unsigned SH  = M_W - OUT_FRAC_W;
    localparam int unsigned Q   = 60;

`ifdef MATH_POW2_ROUND_EN
    localparam int unsigned RND_ADD = (SH > 0) ? (32'd1 << (SH - 1)) : 32'd0;
`else
    localparam int unsigned RND_ADD = 32'd0;
`endif

    // Square root of a Q.60 value, result in Q.60 (bit-by-bit integer sqrt).
    function automatic logic [127:0] isqrt_q(input logic [127:0] x);
        logic [127:0] n;
        logic [127:0] r;
        logic [127:0] t;
        n = x << Q;
        r = '0;
        for (int b = 62; b >= 0; b--) begin
            t = r | (128'd1 << b);
            if ((t * t) <= n) r = t;
        end
        return r;
    endfunction

    // ROM entry k = round((2^(k/2^FRAC_W) - 1) * 2^M_W), evaluated at elaboration.
    // 2^(k/2^F) is built as the product of 2^(2^-j) for each set bit of k.
    function automatic logic [M_W-1:0] lut_entry(input int unsigned k);
        logic [127:0] root;
        logic [127:0] acc;
        logic [127:0] ent;
        root = 128'd2 << Q;
        acc  = 128'd1 << Q;
        for (int j = 1; j <= int'(FRAC_W); j++) begin
            root = isqrt_q(root);
            if (k[FRAC_W-j]) acc = (acc * root) >> Q;
        end
        ent = (acc - (128'd1 << Q) + (128'd1 << (Q - 1 - M_W))) >> (Q - M_W);
        return ent[M_W-1:0];
    endfunction

    logic [M_W-1:0] w_lut [2**FRAC_W];

    for (genvar k = 0; k < 2**FRAC_W; k++) begin : g_lut
        localparam logic [M_W-1:0] ENTRY = lut_entry(k);
        assign w_lut[k] = ENTRY;
    end

    // Stage registers
    logic                 r_v1, r_v2, r_v3;
    logic [INT_W-1:0]     r_e1;
    logic [M_W:0]         r_m1;
    logic                 r_ovf1, r_ovf2, r_ovf3;
    logic [TAG_W-1:0]     r_tag1, r_tag2, r_tag3;
    logic [P_W-1:0]       r_p2;
    logic [D_W-1:0]       r_dout3;

    logic                 w_adv;
    logic [INT_W-1:0]     w_e;
    logic [FRAC_W-1:0]    w_frac;
    logic [M_W:0]         w_m;
    logic                 w_ovf;
    logic [P_W-1:0]       w_p;
    logic [S_W-1:0]       w_sum;
    logic [S_W-1:0]       w_q;
    logic                 w_carry;
    logic                 w_sat;
    logic [D_W-1:0]       w_dout;

    assign w_adv    = !r_v3 || out_ready;
    assign in_ready = w_adv;

    // S1: split exponent, look up mantissa with hidden one
    assign w_e    = din[INT_W+FRAC_W-1:FRAC_W];
    assign w_frac = din[FRAC_W-1:0];
    assign w_m    = {1'b1, w_lut[w_frac]};
    assign w_ovf  = (32'(w_e) >= OUT_INT_W);

    // S2: shift only for in-range exponents so the product never loses bits
    assign w_p = r_ovf1 ? P_W'(r_m1) : (P_W'(r_m1) << r_e1);

    // S3: optional rounding, rescale, saturate on range overflow or rounding carry
    assign w_sum   = {1'b0, r_p2} + S_W'(RND_ADD);
    assign w_q     = w_sum >> SH;
    assign w_carry = |w_q[S_W-1:D_W];
    assign w_sat   = r_ovf2 || w_carry;
    assign w_dout  = w_sat ? {D_W{1'b1}} : w_q[D_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_e1    <= '0;
            r_m1    <= '0;
            r_ovf1  <= 1'b0;
            r_tag1  <= '0;
            r_p2    <= '0;
            r_ovf2  <= 1'b0;
            r_tag2  <= '0;
            r_dout3 <= '0;
            r_ovf3  <= 1'b0;
            r_tag3  <= '0;
        end else if (w_adv) begin
            // Valids always move; data registers only load real samples.
            r_v1 <= in_valid;
            if (in_valid) begin
                r_e1   <= w_e;
                r_m1   <= w_m;
                r_ovf1 <= w_ovf;
                r_tag1 <= in_tag;
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_p2   <= w_p;
                r_ovf2 <= r_ovf1;
                r_tag2 <= r_tag1;
            end
            r_v3 <= r_v2;
            if (r_v2) begin
                r_dout3 <= w_dout;
                r_ovf3  <= w_sat;
                r_tag3  <= r_tag2;
            end
        end
    end

    assign out_valid = r_v3;
    assign dout      = r_dout3;
    assign out_ovf   = r_ovf3;
    assign out_tag   = r_tag3;

endmodule

// File: tb/tb_math_pow2_pipe.sv
// Self-checking bench for math_pow2_pipe at default parameters (din 12b, dout 24b).
// Reference: 2^(din/64) * 256 in real arithmetic; saturation iff din[11:6] >= 16.

module tb_math_pow2_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] din;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] dout;
    logic        out_ovf;
    logic [3:0]  out_tag;

    int total = 0;
    int bad   = 0;

`ifdef MATH_POW2_ROUND_EN
    localparam logic [23:0] EXP_001 = 24'd259;
`else
    localparam logic [23:0] EXP_001 = 24'd258;
`endif

    math_pow2_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_ovf   (out_ovf),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%0h want 0x%0h", name, obs, exp);
        end
    endtask

    task automatic chk_ok(input string name, input logic ok, input real obs, input real exp);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s: got %f want %f (+-1)", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the sample currently on the outputs with the real-valued model.
    task automatic check_sample(input string name, input logic [11:0] d, input logic [3:0] etag);
        real ref_v;
        real err;
        chk({name, " tag"}, 32'(out_tag), 32'(etag));
        if (d[11:6] >= 6'd16) begin
            chk({name, " ovf"}, 32'(out_ovf), 32'd1);
            chk({name, " sat"}, 32'(dout), 32'hFFFFFF);
        end else begin
            ref_v = (2.0 ** (real'(d) / 64.0)) * 256.0;
            err   = real'(dout) - ref_v;
            chk({name, " ovf"}, 32'(out_ovf), 32'd0);
            chk_ok({name, " err"}, (err <= 1.0) && (err >= -1.0), real'(dout), ref_v);
        end
    endtask

    // Single sample through an empty pipeline; checks latency and exact result.
    task automatic run_one(input string name, input logic [11:0] d, input logic [3:0] tg,
                           input logic [23:0] exp_dout, input logic exp_ovf);
        int lat;
        in_valid  = 1'b1;
        din       = d;
        in_tag    = tg;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'd3);
        chk({name, " dout"}, 32'(dout), 32'(exp_dout));
        chk({name, " ovf"}, 32'(out_ovf), 32'(exp_ovf));
        chk({name, " tag"}, 32'(out_tag), 32'(tg));
        step();
    endtask

    logic [11:0] sd [8];
    logic [23:0] h_dout;
    logic [3:0]  h_tag;
    logic        h_ovf;
    logic        held;
    int          sent;
    int          got;
    int          q [$];
    int          cur;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst dout", 32'(dout), 32'd0);
        chk("rst ovf", 32'(out_ovf), 32'd0);
        chk("rst tag", 32'(out_tag), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Directed values and boundaries
        run_one("d000", 12'h000, 4'h1, 24'h000100, 1'b0);
        run_one("d040", 12'h040, 4'h2, 24'h000200, 1'b0);
        run_one("d3C0", 12'h3C0, 4'h3, 24'h800000, 1'b0);
        run_one("d400", 12'h400, 4'h4, 24'hFFFFFF, 1'b1);
        run_one("d001", 12'h001, 4'h5, EXP_001, 1'b0);
        run_one("d020", 12'h020, 4'h6, 24'd362, 1'b0);
        run_one("dFFF", 12'hFFF, 4'h7, 24'hFFFFFF, 1'b1);

        // Stream of 8 tagged samples with a 5-cycle output stall
        for (int i = 0; i < 8; i++) sd[i] = 12'($urandom_range(0, 4095));
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            in_valid  = (sent < 8);
            din       = sd[sent % 8];
            in_tag    = 4'(sent + 3);
            out_ready = !(cyc >= 4 && cyc <= 8);
            #4;
            if (cyc >= 4 && cyc <= 8) begin
                chk("hold in_ready", 32'(in_ready), 32'd0);
                chk("hold out_valid", 32'(out_valid), 32'd1);
                if (cyc == 4) begin
                    h_dout = dout;
                    h_tag  = out_tag;
                end else begin
                    chk("hold dout", 32'(dout), 32'(h_dout));
                    chk("hold tag", 32'(out_tag), 32'(h_tag));
                end
            end
            if (out_valid && out_ready) begin
                check_sample("stream", sd[got], 4'(got + 3));
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream count", 32'(got), 32'd8);
        repeat (4) step();
        chk("stream drained", 32'(out_valid), 32'd0);

        // Asynchronous reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            din      = 12'(12'h0C5 + i);
            in_tag   = 4'(9 + i);
            step();
        end
        in_valid = 1'b0;
        chk("inflight out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async dout", 32'(dout), 32'd0);
        chk("async ovf", 32'(out_ovf), 32'd0);
        chk("async tag", 32'(out_tag), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("post-rst no stale", 32'(out_valid), 32'd0);
            step();
        end
        run_one("post-rst", 12'h040, 4'hA, 24'h000200, 1'b0);

        // Full code sweep under random valid/ready
        cur  = 0;
        got  = 0;
        held = 1'b0;
        for (int cyc = 0; cyc < 30000 && got < 4096; cyc++) begin
            in_valid  = (cur < 4096) && ($urandom_range(0, 3) != 0);
            din       = 12'(cur);
            in_tag    = 4'(cur);
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            if (held) begin
                chk("sweep stall valid", 32'(out_valid), 32'd1);
                chk("sweep stall dout", 32'(dout), 32'(h_dout));
                chk("sweep stall ovf", 32'(out_ovf), 32'(h_ovf));
                chk("sweep stall tag", 32'(out_tag), 32'(h_tag));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sweep extra output", 32'd1, 32'd0);
                end else begin
                    check_sample("sweep", 12'(q[0]), 4'(q[0]));
                    void'(q.pop_front());
                end
                got++;
            end
            held   = out_valid && !out_ready;
            h_dout = dout;
            h_ovf  = out_ovf;
            h_tag  = out_tag;
            if (in_valid && in_ready) begin
                q.push_back(cur);
                cur++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("sweep count", 32'(got), 32'd4096);
        chk("sweep queue empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
